// File: rtl/rv_mul_pkg.sv
// rtl/rv_mul_pkg.sv - shared constants and encodings for the byte-serial multiply unit
package rv_mul_pkg;

  localparam int MUL_NSTEPS = 10;
  localparam int STEP_W     = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    BSEL_B0 = 2'b00,
    BSEL_B1 = 2'b01,
    BSEL_B2 = 2'b10,
    BSEL_B3 = 2'b11
  } bsel_e;

  // Writeback mux select code that routes mul_res to the register file.
  localparam logic [2:0] WB_MUL_RES = 3'd3;

endpackage

// File: rtl/rv_mul_pp.sv
// rtl/rv_mul_pp.sv - byte select, 8x8 multiply and shift for one partial product
module rv_mul_pp
  import rv_mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [1:0]      i_sel_a,
  input  logic [1:0]      i_sel_b,
  input  logic [4:0]      i_shift,
  output logic [XLEN-1:0] o_pp
);

  logic [BYTE_W-1:0]   w_byte_a;
  logic [BYTE_W-1:0]   w_byte_b;
  logic [2*BYTE_W-1:0] w_prod;
  logic [XLEN-1:0]     w_prod_ext;

  assign w_byte_a   = i_a[BYTE_W*i_sel_a +: BYTE_W];
  assign w_byte_b   = i_b[BYTE_W*i_sel_b +: BYTE_W];
  assign w_prod     = w_byte_a * w_byte_b;
  assign w_prod_ext = {{(XLEN-2*BYTE_W){1'b0}}, w_prod};
  // Bits shifted past XLEN are dropped: only the low word of the product is kept.
  assign o_pp       = w_prod_ext << i_shift;

endmodule

// File: rtl/rv_mul_unit.sv
// rtl/rv_mul_unit.sv - byte-serial RV32M MUL datapath driven by the control FSM step controls
module rv_mul_unit
  import rv_mul_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSTEPS   = MUL_NSTEPS,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [1:0]      Ma_sel,
  input  logic [1:0]      Mb_sel,
  input  logic [4:0]      Mshift_val,
  input  logic            Mupd_reg,
  input  logic            Mclr_reg,
  output logic [XLEN-1:0] mul_res,
  output logic            mul_done,
  output logic            mul_err
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_opa;
  logic [XLEN-1:0]   r_opb;
  logic [STEP_W-1:0] r_step_cnt;
  logic              r_done;
  logic              r_err;

  logic              w_first;
  logic [XLEN-1:0]   w_src_a;
  logic [XLEN-1:0]   w_src_b;
  logic [XLEN-1:0]   w_pp;
  logic [2:0]        w_sel_sum;
  logic [5:0]        w_exp_shift;
  logic              w_shift_bad;

  // Step 0 multiplies the live operands; later steps use the copies latched then.
  assign w_first = (r_step_cnt == '0);
  assign w_src_a = w_first ? op_a : r_opa;
  assign w_src_b = w_first ? op_b : r_opb;

  rv_mul_pp #(.XLEN(XLEN)) u_pp (
    .i_a     (w_src_a),
    .i_b     (w_src_b),
    .i_sel_a (Ma_sel),
    .i_sel_b (Mb_sel),
    .i_shift (Mshift_val),
    .o_pp    (w_pp)
  );

  assign w_sel_sum   = {1'b0, Ma_sel} + {1'b0, Mb_sel};
  assign w_exp_shift = {w_sel_sum, 3'b000};
  assign w_shift_bad = CHECK_EN && ({1'b0, Mshift_val} != w_exp_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_step_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (Mclr_reg) begin
      r_acc      <= '0;
      r_step_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (Mupd_reg) begin
      if (w_first) begin
        r_opa <= op_a;
        r_opb <= op_b;
        r_acc <= w_pp;
      end else begin
        r_acc <= r_acc + w_pp;
      end
      if (r_step_cnt == LAST_STEP) begin
        r_step_cnt <= '0;
        r_done     <= 1'b1;
      end else begin
        r_step_cnt <= r_step_cnt + STEP_W'(1);
        r_done     <= 1'b0;
      end
      if (w_shift_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mul_res  = r_acc;
  assign mul_done = r_done;
  assign mul_err  = r_err;

endmodule

// File: tb/tb_rv_mul_unit.sv
// tb/tb_rv_mul_unit.sv - directed and randomized checks of rv_mul_unit against an arithmetic model
module tb_rv_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  Ma_sel;
  logic [1:0]  Mb_sel;
  logic [4:0]  Mshift_val;
  logic        Mupd_reg;
  logic        Mclr_reg;
  logic [31:0] mul_res;
  logic        mul_done;
  logic        mul_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ord_a[10];
  int ord_b[10];

  always #5 clk = ~clk;

  rv_mul_unit #(.XLEN(32), .NSTEPS(10), .CHECK_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_a       (op_a),
    .op_b       (op_b),
    .Ma_sel     (Ma_sel),
    .Mb_sel     (Mb_sel),
    .Mshift_val (Mshift_val),
    .Mupd_reg   (Mupd_reg),
    .Mclr_reg   (Mclr_reg),
    .mul_res    (mul_res),
    .mul_done   (mul_done),
    .mul_err    (mul_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic std_order();
    int idx = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j <= 3 - i; j++) begin
        ord_a[idx] = i;
        ord_b[idx] = j;
        idx++;
      end
  endtask

  task automatic shuffle_order();
    for (int k = 9; k > 0; k--) begin
      int r = $urandom_range(k, 0);
      int ta = ord_a[k];
      int tb = ord_b[k];
      ord_a[k] = ord_a[r]; ord_b[k] = ord_b[r];
      ord_a[r] = ta;       ord_b[r] = tb;
    end
  endtask

  // Called at a falling edge; returns at the following falling edge with strobes dropped.
  task automatic apply(input logic upd, input logic clr, input logic [1:0] as,
                       input logic [1:0] bs, input logic [4:0] sh);
    Mupd_reg = upd; Mclr_reg = clr; Ma_sel = as; Mb_sel = bs; Mshift_val = sh;
    @(posedge clk);
    @(negedge clk);
    Mupd_reg = 1'b0; Mclr_reg = 1'b0;
    Ma_sel = 2'($urandom); Mb_sel = 2'($urandom); Mshift_val = 5'($urandom);
  endtask

  // Drives n steps of the current pair order; after step 0 the A/B registers move on.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int n,
                         input bit zero_after0, input int bad_step);
    for (int k = 0; k < n; k++) begin
      logic [4:0] sh;
      if (k == 0) begin
        op_a = a; op_b = b;
      end else if (zero_after0) begin
        op_a = 32'h0; op_b = 32'h0;
      end else begin
        op_a = $urandom; op_b = $urandom;
      end
      sh = 5'(8 * (ord_a[k] + ord_b[k]));
      if (k == bad_step) sh = sh - 5'd8;
      apply(1'b1, 1'b0, 2'(ord_a[k]), 2'(ord_b[k]), sh);
      if (k == 0) check("done_low_after_step0", {31'b0, mul_done}, 32'd0);
    end
  endtask

  function automatic logic [31:0] bad_model(input logic [31:0] a, input logic [31:0] b,
                                             input int bad_step);
    logic [63:0] sum = 64'd0;
    for (int k = 0; k < 10; k++) begin
      longint unsigned ba = (a >> (8 * ord_a[k])) & 32'hFF;
      longint unsigned bb = (b >> (8 * ord_b[k])) & 32'hFF;
      int sh = 8 * (ord_a[k] + ord_b[k]) - ((k == bad_step) ? 8 : 0);
      if (sh < 32) sum = sum + ((ba * bb) << sh);
    end
    return sum[31:0];
  endfunction

  task automatic check_result(input string tag, input logic [31:0] exp, input logic exp_err);
    check({tag, "_res"}, mul_res, exp);
    check({tag, "_done"}, {31'b0, mul_done}, 32'd1);
    check({tag, "_err"}, {31'b0, mul_err}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] held;
    rst = 1'b1; op_a = '0; op_b = '0; Ma_sel = '0; Mb_sel = '0;
    Mshift_val = '0; Mupd_reg = 1'b0; Mclr_reg = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_res", mul_res, 32'd0);
    check("reset_done", {31'b0, mul_done}, 32'd0);
    check("reset_err", {31'b0, mul_err}, 32'd0);

    std_order();
    run_mul(32'h00010003, 32'h00020005, 10, 1'b0, -1);
    check_result("basic", 32'h000B000F, 1'b0);

    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 10, 1'b1, -1);
    check_result("latched", 32'h00000001, 1'b0);

    run_mul(32'd7, 32'd6, 10, 1'b0, -1);
    check_result("b2b_first", 32'h0000002A, 1'b0);
    run_mul(32'h80000000, 32'd2, 10, 1'b0, -1);
    check_result("b2b_second", 32'h00000000, 1'b0);

    run_mul(32'h12345678, 32'h9ABCDEF1, 5, 1'b0, -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_res", mul_res, 32'd0);
    check("midrst_done", {31'b0, mul_done}, 32'd0);
    check("midrst_err", {31'b0, mul_err}, 32'd0);
    run_mul(32'd6, 32'd7, 10, 1'b0, -1);
    check_result("after_rst", 32'h0000002A, 1'b0);

    run_mul(32'hDEADBEEF, 32'hCAFEF00D, 3, 1'b0, -1);
    apply(1'b1, 1'b1, 2'(ord_a[3]), 2'(ord_b[3]), 5'(8 * (ord_a[3] + ord_b[3])));
    check("clr_upd_res", mul_res, 32'd0);
    check("clr_upd_done", {31'b0, mul_done}, 32'd0);
    a = 32'h12345678; b = 32'h9ABCDEF0;
    run_mul(a, b, 10, 1'b0, -1);
    check_result("after_clr", a * b, 1'b0);

    a = 32'h01020304; b = 32'h05060708;
    run_mul(a, b, 5, 1'b0, 4);
    check("err_set", {31'b0, mul_err}, 32'd1);
    run_mul(a, b, 0, 1'b0, -1);
    for (int k = 5; k < 10; k++) begin
      op_a = $urandom; op_b = $urandom;
      apply(1'b1, 1'b0, 2'(ord_a[k]), 2'(ord_b[k]), 5'(8 * (ord_a[k] + ord_b[k])));
    end
    check_result("err_sticky", bad_model(a, b, 4), 1'b1);
    apply(1'b0, 1'b1, 2'd0, 2'd0, 5'd0);
    check("err_cleared", {31'b0, mul_err}, 32'd0);
    check("clr_res", mul_res, 32'd0);

    for (int t = 0; t < 6; t++) begin
      a = $urandom; b = $urandom;
      std_order();
      shuffle_order();
      run_mul(a, b, 10, 1'b0, -1);
      check_result("random", a * b, 1'b0);
    end

    held = mul_res;
    repeat (5) begin
      op_a = $urandom; op_b = $urandom;
      apply(1'b0, 1'b0, 2'($urandom), 2'($urandom), 5'($urandom));
    end
    check("idle_hold_res", mul_res, held);
    check("idle_hold_done", {31'b0, mul_done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
